// File: rtl/pulse_burst_detector.sv
// Self-checking receiver for a serial pulse train: validates high widths and low gaps,
// flags a completed burst of PULSES good pulses with done and any violation with error.
module pulse_burst_detector #(
  parameter int unsigned PULSES   = 2,
  parameter int unsigned MIN_HIGH = 2,
  parameter int unsigned MAX_HIGH = 4,
  parameter int unsigned MAX_GAP  = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             signal,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned WID_W = $clog2(MAX_HIGH + 2);
  localparam int unsigned GAP_W = $clog2(MAX_GAP + 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HIGH  = 3'd1,
    ST_LOW   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, s_q, s_d_q;
  logic [WID_W-1:0]   width_q, width_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   count_d;
  logic [CNT_W-1:0]   count_inc;
  logic               busy_d, done_d, error_d;
  logic               rise, fall;

  // Two-flop synchronizer plus one delay stage for edge detection; runs regardless of enable
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      s_d_q   <= 1'b0;
    end else begin
      sync1_q <= signal;
      s_q     <= sync1_q;
      s_d_q   <= s_q;
    end
  end

  assign rise      = s_q & ~s_d_q;
  assign fall      = ~s_q & s_d_q;
  assign count_inc = count + CNT_W'(1);

  // State, counters and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      width_q <= '0;
      gap_q   <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      gap_q   <= gap_d;
      count   <= count_d;
      busy    <= busy_d;
      done    <= done_d;
      error   <= error_d;
    end
  end

  // Next-state, counter updates and next output values
  always_comb begin
    state_d = state_q;
    width_d = width_q;
    gap_d   = gap_q;
    count_d = count;

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_HIGH;
            width_d = WID_W'(1);
            count_d = '0;
          end
        end
        ST_HIGH: begin
          if (s_q) begin
            if (width_q >= WID_W'(MAX_HIGH)) begin
              state_d = ST_ERROR;
            end
            if (width_q != WID_W'(MAX_HIGH + 1)) begin
              width_d = width_q + WID_W'(1);
            end
          end else if (width_q < WID_W'(MIN_HIGH)) begin
            state_d = ST_ERROR;
          end else begin
            count_d = count_inc;
            if (count_inc == CNT_W'(PULSES)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_LOW;
              gap_d   = GAP_W'(1);
            end
          end
        end
        ST_LOW: begin
          if (rise) begin
            state_d = ST_HIGH;
            width_d = WID_W'(1);
          end else if (!s_q) begin
            if (gap_q >= GAP_W'(MAX_GAP)) begin
              state_d = ST_ERROR;
            end
            if (gap_q != GAP_W'(MAX_GAP + 1)) begin
              gap_d = gap_q + GAP_W'(1);
            end
          end
        end
        ST_DONE: begin
          // A rise coinciding with done is deliberately dropped
          state_d = ST_IDLE;
        end
        ST_ERROR: begin
          if (!s_q) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d  = (state_d == ST_HIGH) || (state_d == ST_LOW) || (state_d == ST_ERROR);
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERROR) && (state_q != ST_ERROR);
  end

  // fall is implied by (state HIGH, s low); kept for readability of edge intent
  logic unused_fall;
  assign unused_fall = fall;

endmodule

// File: tb/tb_pulse_burst_detector.sv
// Bench for pulse_burst_detector: table of pulse-train scenarios feeding an event
// scoreboard, plus hand-written reset, timing and enable sequences.
module tb_pulse_burst_detector;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       signal;
  logic       busy, done, error;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       is_err;
    logic [3:0] cnt;
  } ev_t;

  ev_t sb[$];

  // kind: 0 none, 1 done, 2 error
  typedef struct {
    int h0; int g0; int h1; int g1; int h2;
    int k0; int c0; int k1; int c1;
    int fcnt;
  } vec_t;

  pulse_burst_detector dut (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .signal  (signal),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .count   (count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    signal = v;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input int kind, input int cnt);
    ev_t e;
    if (kind != 0) begin
      e.is_err = (kind == 2);
      e.cnt    = 4'(cnt);
      sb.push_back(e);
    end
  endtask

  // Every done/error pulse must match the oldest expected event
  always @(negedge clock) begin
    if (reset_n && (done || error)) begin
      if (done && error) begin
        check("done_and_error", 1, 0);
      end
      if (sb.size() == 0) begin
        check("unexpected_event", {30'd0, error, done}, 0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("event_kind", int'(error), int'(e.is_err));
        check("event_count", int'(count), int'(e.cnt));
      end
    end
  end

  initial begin
    vec_t vt[10];

    vt[0] = '{3, 3, 3, 0, 0,  1, 2, 0, 0,  2};  // good burst
    vt[1] = '{1, 0, 0, 0, 0,  2, 0, 0, 0,  0};  // short pulse
    vt[2] = '{8, 0, 0, 0, 0,  2, 0, 0, 0,  0};  // long pulse, single error
    vt[3] = '{3, 6, 3, 0, 0,  2, 1, 2, 1,  1};  // long gap, new burst then gap timeout
    vt[4] = '{2, 1, 4, 0, 0,  1, 2, 0, 0,  2};  // min width, min gap, max width
    vt[5] = '{4, 4, 2, 0, 0,  1, 2, 0, 0,  2};  // max gap accepted
    vt[6] = '{5, 0, 0, 0, 0,  2, 0, 0, 0,  0};  // one past max width
    vt[7] = '{3, 5, 3, 0, 0,  2, 1, 0, 0,  1};  // one past max gap, pulse swallowed in ERROR
    vt[8] = '{3, 2, 1, 0, 0,  2, 1, 0, 0,  1};  // second pulse too short
    vt[9] = '{3, 3, 3, 3, 3,  1, 2, 2, 1,  1};  // burst then a fresh partial burst

    reset_n = 1'b0;
    enable  = 1'b1;
    signal  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_count", int'(count), 0);
    reset_n = 1'b1;
    drive(1'b0, 4);

    // Table-driven scenarios
    for (int i = 0; i < 10; i++) begin
      push(vt[i].k0, vt[i].c0);
      push(vt[i].k1, vt[i].c1);
      drive(1'b1, vt[i].h0);
      if (vt[i].h1 > 0) begin
        drive(1'b0, vt[i].g0);
        drive(1'b1, vt[i].h1);
      end
      if (vt[i].h2 > 0) begin
        drive(1'b0, vt[i].g1);
        drive(1'b1, vt[i].h2);
      end
      drive(1'b0, 16);
      check($sformatf("vec%0d_missing_events", i), sb.size(), 0);
      check($sformatf("vec%0d_count", i), int'(count), vt[i].fcnt);
      check($sformatf("vec%0d_busy", i), int'(busy), 0);
      sb.delete();
    end

    // Short pulse timing: error exactly 4 edges after signal rises, for one cycle
    push(2, 0);
    signal = 1'b1;
    @(posedge clock); #1;
    signal = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("short_err_early", int'(error), 0);
    @(posedge clock); #1;
    check("short_err_at_fall", int'(error), 1);
    check("short_busy_in_err", int'(busy), 1);
    @(posedge clock); #1;
    check("short_err_one_cycle", int'(error), 0);
    check("short_idle", int'(busy), 0);
    drive(1'b0, 6);
    check("short_sb_empty", sb.size(), 0);

    // Long pulse timing: error on the 5th high cycle at s (edge 7 after drive)
    push(2, 0);
    signal = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock); #1;
      if (k == 6) check("long_err_early", int'(error), 0);
      if (k == 7) check("long_err_on_time", int'(error), 1);
      if (k == 8) check("long_busy_while_high", int'(busy), 1);
    end
    drive(1'b0, 10);
    check("long_idle", int'(busy), 0);
    check("long_sb_empty", sb.size(), 0);

    // Asynchronous reset in the middle of the second pulse
    drive(1'b1, 3);
    drive(1'b0, 2);
    drive(1'b1, 2);
    check("pre_rst_count", int'(count), 1);
    check("pre_rst_busy", int'(busy), 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_count", int'(count), 0);
    check("async_rst_err", int'(error), 0);
    signal = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    drive(1'b0, 10);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_sb_empty", sb.size(), 0);

    // Enable dropped mid-burst, then re-enabled while signal is high
    drive(1'b1, 3);
    drive(1'b0, 3);
    check("en_count_mid", int'(count), 1);
    check("en_busy_mid", int'(busy), 1);
    enable = 1'b0;
    drive(1'b0, 1);
    check("en_off_busy", int'(busy), 0);
    drive(1'b1, 3);
    drive(1'b0, 10);
    check("en_off_count", int'(count), 1);
    drive(1'b1, 6);
    enable = 1'b1;
    drive(1'b1, 6);
    check("en_reenable_high_idle", int'(busy), 0);
    drive(1'b0, 10);
    check("en_final_busy", int'(busy), 0);
    check("en_final_count", int'(count), 1);
    check("en_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
